uart_hex_reply_tx: RTL and testbench
====================================

# uart_hex_reply_tx

- Transmit-side counterpart of the command receive path; produces the console reply to a read command.
- Accepts a binary data word and serialises it on one UART line as uppercase ASCII hex digits, most significant nibble first, terminated by CR LF.
- Contains its own 8N1 bit serialiser and needs no separate transmit core.
- Sits between the register-read mux and the board TXD pin.

## Interface
Parameters:
- C_F_CK, 135_000_000, clock frequency in Hz
- C_BAUD, 112_500, line rate in bit/s; bit period C_BAUD_N = C_F_CK / C_BAUD clocks (integer division); legal range 2..65536
- C_NIBBLES, 4, hex digits per reply; legal range 1..8

Ports:
- CK_i  in  1  clock
- XARST_i  in  1  reset; asynchronous, active-low
- DATs_i  in  4*C_NIBBLES  word to print; sampled only at acceptance
- REQ_i  in  1  request, level-sensitive
- ACK_o  out  1  one-cycle pulse; request accepted and DATs_i captured
- BUSY_o  out  1  high while a reply frame is in progress
- TXD_o  out  1  serial output; idle high
- DONE_o  out  1  one-cycle pulse; stop bit of LF completed

## Operation
- Reset values: TXD_o=1, BUSY_o=0, ACK_o=0, DONE_o=0. All counters and state return to IDLE.
- Acceptance occurs at a rising edge where REQ_i=1 and BUSY_o=0. At that edge:
  - DATs_i is latched.
  - ACK_o=1 for one cycle.
  - BUSY_o=1.
  - TXD_o=0, which is the start bit of the first character.
- Reply content is C_NIBBLES+2 characters, sent back-to-back with no inter-character gap:
  - digit k (k=0 is the MS nibble) maps 0..9 to 0x30..0x39 and A..F to 0x41..0x46
  - then 0x0D, then 0x0A
- Character frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts exactly C_BAUD_N clocks.
- State machine:
  - IDLE -> START on acceptance
  - START -> DATA after C_BAUD_N clocks
  - DATA (bit index 0..7) -> STOP after 8*C_BAUD_N clocks
  - STOP -> START of the next character after C_BAUD_N clocks, or -> IDLE after the last character
- Counters:
  - bit counter: 16-bit down-counter, reload C_BAUD_N-1
  - character index: 0..C_NIBBLES+1; no wrap within a frame
- A REQ_i asserted while BUSY_o=1 is ignored; no queueing. DATs_i changes during a frame have no effect.
- When REQ_i is held high continuously, a new frame is accepted at every IDLE opportunity, and fresh DATs_i is captured each time.

## Timing
- Acceptance edge is T0.
- Start bit of character c begins at edge T0 + c*10*C_BAUD_N.
- Data bit b of character c begins at edge T0 + (c*10 + 1 + b)*C_BAUD_N.
- At edge T0 + 10*(C_NIBBLES+2)*C_BAUD_N:
  - BUSY_o goes 0
  - DONE_o pulses for one cycle
  - TXD_o stays 1
- Next acceptance is possible at the following edge at the earliest, so back-to-back frames have 1 extra idle-high clock plus the stop bit.
- ACK_o and DONE_o are never high in the same cycle.
- Reset asserted mid-frame:
  - all outputs return to reset values immediately, without waiting for a clock
  - no DONE_o pulse is produced for the aborted frame
  - after release, the block is in IDLE and accepts on the first qualifying edge

## Test plan
All scenarios use C_F_CK=1000, C_BAUD=100 (C_BAUD_N=10), C_NIBBLES=4 unless stated.
1. Reset: hold XARST_i low 3 clocks -> TXD_o=1, BUSY_o=0, ACK_o=0, DONE_o=0 throughout; REQ_i=1 during reset produces no ACK_o.
2. DATs_i=16'h90AF, one-cycle REQ_i -> UART_RX_CORE in loopback receives 0x39,0x30,0x41,0x46,0x0D,0x0A in order. ACK_o pulses once at T0. DONE_o pulses at T0+600, and BUSY_o is high for exactly 600 clocks.
3. DATs_i=16'h0000, then 16'hFFFF -> every bit measured on TXD_o is exactly 10 clocks wide. Start bits fall at T0+0,100,...,500, and the characters are '0' ×4 and 'F' ×4 followed by CR LF.
4. REQ_i held high, DATs_i changed to 16'h1234 mid-frame -> second ACK_o comes 1 clock after DONE_o. The second frame carries "1234\r\n" and the first frame is unaffected.
5. C_NIBBLES=1, DATs_i=4'hA -> 0x41,0x0D,0x0A; DONE_o at T0+300.
6. Reset pulsed at T0+250 (inside the third character) -> TXD_o=1 and BUSY_o=0 immediately, with no DONE_o pulse. After release, a new request for 16'h5A5A sends the complete "5A5A\r\n".

Source files
------------

// File: rtl/uart_hex_reply_tx.sv
// Serialises a captured data word as uppercase ASCII hex digits (MS nibble first),
// followed by CR LF, on a single 8N1 UART line. Each frame starts on acceptance of REQ_i.
module uart_hex_reply_tx #(
    parameter int unsigned C_F_CK    = 135_000_000,
    parameter int unsigned C_BAUD    = 112_500,
    parameter int unsigned C_NIBBLES = 4
) (
    input  logic                   CK_i,
    input  logic                   XARST_i,
    input  logic [4*C_NIBBLES-1:0] DATs_i,
    input  logic                   REQ_i,
    output logic                   ACK_o,
    output logic                   BUSY_o,
    output logic                   TXD_o,
    output logic                   DONE_o
);

    localparam int unsigned CBaudN  = C_F_CK / C_BAUD;
    localparam int unsigned DW      = 4 * C_NIBBLES;
    localparam logic [15:0] BitLast = 16'(CBaudN - 1);
    localparam logic [3:0]  ChrLast = 4'(C_NIBBLES + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [15:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [3:0]      chr_idx_q, chr_idx_d;
    logic [DW-1:0]   data_q, data_d;
    logic [7:0]      sh_q, sh_d;
    logic            txd_q, txd_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // ASCII code of character idx of the reply for word w: hex digits, then CR, then LF.
    function automatic logic [7:0] char_of(input logic [DW-1:0] w, input logic [3:0] idx);
        logic [3:0] nib;
        logic [7:0] c;
        nib = 4'h0;
        for (int k = 0; k < int'(C_NIBBLES); k++) begin
            if (idx == 4'(k)) begin
                nib = w[4*(int'(C_NIBBLES)-1-k) +: 4];
            end
        end
        if (32'(idx) < C_NIBBLES) begin
            c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (idx == 4'(C_NIBBLES)) begin
            c = 8'h0D;
        end else begin
            c = 8'h0A;
        end
        return c;
    endfunction

    // Next-state logic: bit timing, shift register and character sequencing.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        chr_idx_d = chr_idx_q;
        data_d    = data_q;
        sh_d      = sh_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (REQ_i) begin
                    data_d    = DATs_i;
                    sh_d      = char_of(DATs_i, 4'd0);
                    chr_idx_d = 4'd0;
                    bit_cnt_d = BitLast;
                    ack_d     = 1'b1;
                    busy_d    = 1'b1;
                    txd_d     = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_cnt_q == 16'd0) begin
                    bit_cnt_d = BitLast;
                    bit_idx_d = 3'd0;
                    txd_d     = sh_q[0];
                    sh_d      = {1'b0, sh_q[7:1]};
                    state_d   = StData;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            StData: begin
                if (bit_cnt_q == 16'd0) begin
                    bit_cnt_d = BitLast;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = sh_q[0];
                        sh_d      = {1'b0, sh_q[7:1]};
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (bit_cnt_q == 16'd0) begin
                    if (chr_idx_q == ChrLast) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        chr_idx_d = chr_idx_q + 4'd1;
                        sh_d      = char_of(data_q, chr_idx_q + 4'd1);
                        bit_cnt_d = BitLast;
                        txd_d     = 1'b0;
                        state_d   = StStart;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset forces the line idle-high at once.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= 16'd0;
            bit_idx_q <= 3'd0;
            chr_idx_q <= 4'd0;
            data_q    <= '0;
            sh_q      <= 8'h00;
            txd_q     <= 1'b1;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            chr_idx_q <= chr_idx_d;
            data_q    <= data_d;
            sh_q      <= sh_d;
            txd_q     <= txd_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ACK_o  = ack_q;
    assign BUSY_o = busy_q;
    assign TXD_o  = txd_q;
    assign DONE_o = done_q;

endmodule

// File: tb/tb_uart_hex_reply_tx.sv
// Bench for uart_hex_reply_tx: a 4-digit and a 1-digit instance checked against a
// reply-string / bit-stream model, with random words and the reset-abort case.
module tb_uart_hex_reply_tx;

    localparam int N = 10;  // C_F_CK / C_BAUD

    logic        clk;
    logic        xarst;
    logic        req4, req1;
    logic [15:0] dat4;
    logic [3:0]  dat1;
    logic        ack4, busy4, txd4, done4;
    logic        ack1, busy1, txd1, done1;

    int n_chk;
    int n_err;

    uart_hex_reply_tx #(.C_F_CK(1000), .C_BAUD(100), .C_NIBBLES(4)) u_dut4 (
        .CK_i    (clk),
        .XARST_i (xarst),
        .DATs_i  (dat4),
        .REQ_i   (req4),
        .ACK_o   (ack4),
        .BUSY_o  (busy4),
        .TXD_o   (txd4),
        .DONE_o  (done4)
    );

    uart_hex_reply_tx #(.C_F_CK(1000), .C_BAUD(100), .C_NIBBLES(1)) u_dut1 (
        .CK_i    (clk),
        .XARST_i (xarst),
        .DATs_i  (dat1),
        .REQ_i   (req1),
        .ACK_o   (ack1),
        .BUSY_o  (busy1),
        .TXD_o   (txd1),
        .DONE_o  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reply character c for word w printed with nib digits.
    function automatic int exp_char(input int w, input int nib, input int c);
        int d;
        if (c < nib) begin
            d = (w >> (4 * (nib - 1 - c))) & 15;
            return (d < 10) ? (48 + d) : (65 + d - 10);
        end else if (c == nib) begin
            return 13;
        end
        return 10;
    endfunction

    // Expected line level t clocks after acceptance.
    function automatic int exp_bit(input int w, input int nib, input int t);
        int c;
        int pos;
        c   = t / (10 * N);
        pos = (t / N) % 10;
        if (pos == 0) return 0;
        if (pos == 9) return 1;
        return (exp_char(w, nib, c) >> (pos - 1)) & 1;
    endfunction

    // Raise REQ with word w and check the acceptance edge (T0).
    task automatic accept(input int sel, input int w);
        if (sel == 0) begin
            dat4 = 16'(w);
            req4 = 1'b1;
        end else begin
            dat1 = 4'(w);
            req1 = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("t0_ack",  int'(sel != 0 ? ack1  : ack4),  1);
        check_eq("t0_busy", int'(sel != 0 ? busy1 : busy4), 1);
        check_eq("t0_txd",  int'(sel != 0 ? txd1  : txd4),  0);
        check_eq("t0_done", int'(sel != 0 ? done1 : done4), 0);
    endtask

    // Follow a frame from T0+1 up to T0+upto; end-of-frame checks when upto reaches the end.
    task automatic expect_frame(input int sel, input int w, input int nib, input int upto);
        int len;
        int werr, berr, aerr, derr;
        int c, pos;
        int rx;
        logic o_txd, o_busy, o_ack, o_done;
        len  = 10 * (nib + 2) * N;
        werr = 0; berr = 0; aerr = 0; derr = 0;
        rx   = 0;
        for (int t = 1; t <= upto; t++) begin
            @(posedge clk);
            #1;
            o_txd  = (sel != 0) ? txd1  : txd4;
            o_busy = (sel != 0) ? busy1 : busy4;
            o_ack  = (sel != 0) ? ack1  : ack4;
            o_done = (sel != 0) ? done1 : done4;
            if (t < len) begin
                if (int'(o_txd) != exp_bit(w, nib, t)) werr++;
                if (o_busy != 1'b1) berr++;
                if (o_ack != 1'b0) aerr++;
                if (o_done != 1'b0) derr++;
                c   = t / (10 * N);
                pos = (t / N) % 10;
                if (t % (10 * N) == 0) begin
                    check_eq($sformatf("start%0d", c), int'(o_txd), 0);
                end
                if (t % N == N / 2) begin
                    if (pos >= 1 && pos <= 8) rx = rx | (int'(o_txd) << (pos - 1));
                    if (pos == 9) begin
                        check_eq($sformatf("chr%0d", c), rx, exp_char(w, nib, c));
                        rx = 0;
                    end
                end
            end else begin
                check_eq("end_done", int'(o_done), 1);
                check_eq("end_busy", int'(o_busy), 0);
                check_eq("end_txd",  int'(o_txd),  1);
                check_eq("end_ack",  int'(o_ack),  0);
            end
        end
        check_eq("wave_err", werr, 0);
        check_eq("busy_err", berr, 0);
        check_eq("ack_err",  aerr, 0);
        check_eq("done_err", derr, 0);
    endtask

    initial begin
        int w;
        int dcount;
        n_chk = 0;
        n_err = 0;
        xarst = 1'b0;
        req4  = 1'b1;
        req1  = 1'b1;
        dat4  = 16'h0;
        dat1  = 4'h0;

        // Reset held with REQ high: outputs at reset values, no acknowledge.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_txd",  int'(txd4),  1);
            check_eq("rst_busy", int'(busy4), 0);
            check_eq("rst_ack",  int'(ack4),  0);
            check_eq("rst_done", int'(done4), 0);
            check_eq("rst_ack1", int'(ack1),  0);
        end
        req4 = 1'b0;
        req1 = 1'b0;
        xarst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single-cycle request; input word scrambled after capture.
        accept(0, 16'h90AF);
        req4 = 1'b0;
        dat4 = 16'($urandom);
        expect_frame(0, 16'h90AF, 4, 600);

        accept(0, 16'h0000);
        req4 = 1'b0;
        expect_frame(0, 16'h0000, 4, 600);
        repeat (3) @(posedge clk);
        #1;
        accept(0, 16'hFFFF);
        req4 = 1'b0;
        expect_frame(0, 16'hFFFF, 4, 600);

        // REQ held: next acceptance one clock after DONE with fresh data.
        w = int'(16'($urandom));
        accept(0, w);
        dat4 = 16'h1234;
        expect_frame(0, w, 4, 600);
        @(posedge clk);
        #1;
        check_eq("rearm_ack",  int'(ack4),  1);
        check_eq("rearm_busy", int'(busy4), 1);
        check_eq("rearm_done", int'(done4), 0);
        req4 = 1'b0;
        expect_frame(0, 16'h1234, 4, 600);

        // Random words with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            w = int'(16'($urandom));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            accept(0, w);
            req4 = 1'b0;
            dat4 = 16'($urandom);
            expect_frame(0, w, 4, 600);
        end

        // Single-digit instance.
        accept(1, 4'hA);
        req1 = 1'b0;
        expect_frame(1, 4'hA, 1, 300);
        w = int'(4'($urandom));
        accept(1, w);
        req1 = 1'b0;
        expect_frame(1, w, 1, 300);

        // Reset inside the third character aborts the frame silently.
        accept(0, 16'h90AF);
        req4 = 1'b0;
        expect_frame(0, 16'h90AF, 4, 250);
        #3;
        xarst = 1'b0;
        #1;
        check_eq("abort_txd",  int'(txd4),  1);
        check_eq("abort_busy", int'(busy4), 0);
        check_eq("abort_ack",  int'(ack4),  0);
        check_eq("abort_done", int'(done4), 0);
        repeat (2) @(negedge clk);
        xarst = 1'b1;
        dcount = 0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) dcount++;
        end
        check_eq("abort_quiet", dcount, 0);
        accept(0, 16'h5A5A);
        req4 = 1'b0;
        expect_frame(0, 16'h5A5A, 4, 600);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
